// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit multiplexed 7-segment driver with hex/decimal display,
// leading-zero blanking, decimal points, PWM brightness and overflow dashes.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int CLK_HZ      = 50000000,
   parameter int SCAN_HZ     = 1000,
   parameter int DATA_W      = 16,
   parameter int BRIGHT_W    = 4,
   parameter int SEG_ACT_LOW = 1,
   parameter int SEL_ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  mode,
   input  logic [NUM_DIGITS-1:0] dp_in,
   input  logic                  blank_lz,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [NUM_DIGITS-1:0] character_selector,
   output logic [7:0]            segment,
   output logic                  busy,
   output logic                  overflow
);
   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam int IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int CW  = $clog2(DATA_W + 1);
   localparam int BW  = 4 * NUM_DIGITS;
   localparam logic [111:0] GLYPHS = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         shadow_q, shadow_d, bcd_q, bcd_d, bcd_adj;
   logic [DATA_W-1:0]     bin_q, bin_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0] dp_q, dp_d, sel_q, sel_d, sel_x, lz;
   logic                  ovf_q, ovf_d, sticky_q, sticky_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
   logic [7:0]            seg_q, seg_d, seg_x;
   logic [3:0]            nib;
   logic                  en, blank, wrap;

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++)
         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      bcd_d    = bcd_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      dp_d     = dp_q;
      ovf_d    = ovf_q;
      sticky_d = sticky_q;
      case (state_q)
         IDLE: if (load) begin
            dp_d = dp_in;
            if (mode) begin
               bin_d    = data_in;
               bcd_d    = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               state_d  = CONVERT;
            end else begin
               shadow_d = BW'(data_in);
               ovf_d    = 1'b0;
            end
         end
         // a 1 leaving the top BCD digit means the value reached 10^NUM_DIGITS
         CONVERT: begin
            bcd_d    = {bcd_adj[BW-2:0], bin_q[DATA_W-1]};
            bin_d    = bin_q << 1;
            sticky_d = sticky_q | bcd_adj[BW-1];
            cnt_d    = cnt_q + 1'b1;
            state_d  = cnt_q == CW'(DATA_W - 1) ? COMMIT : CONVERT;
         end
         COMMIT: begin
            shadow_d = bcd_q;
            ovf_d    = sticky_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      wrap    = presc_q == PW'(DIV - 1);
      presc_d = wrap ? '0 : presc_q + 1'b1;
      idx_d   = wrap ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
      pwm_d   = pwm_q + 1'b1;
      lz[NUM_DIGITS-1] = shadow_q[BW-1 -: 4] == 4'd0;
      for (int i = NUM_DIGITS - 2; i >= 0; i--)
         lz[i] = lz[i+1] && shadow_q[4*i +: 4] == 4'd0;
      nib   = shadow_q[{idx_q, 2'b00} +: 4];
      blank = blank_lz && !ovf_q && idx_q != '0 && lz[idx_q];
      en    = pwm_q < brightness || &brightness;
      seg_x = en ? {dp_q[idx_q], ovf_q ? 7'h40 : blank ? 7'h00 : GLYPHS[nib*7 +: 7]} : 8'h00;
      sel_x = en ? NUM_DIGITS'(1) << idx_q : '0;
      seg_d = SEG_ACT_LOW != 0 ? ~seg_x : seg_x;
      sel_d = SEL_ACT_LOW != 0 ? ~sel_x : sel_x;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         bcd_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
         dp_q     <= '0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
         presc_q  <= '0;
         idx_q    <= '0;
         pwm_q    <= '0;
         seg_q    <= SEG_ACT_LOW != 0 ? 8'hFF : 8'h00;
         sel_q    <= SEL_ACT_LOW != 0 ? '1 : '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         bcd_q    <= bcd_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         dp_q     <= dp_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         pwm_q    <= pwm_d;
         seg_q    <= seg_d;
         sel_q    <= sel_d;
      end
   end

   assign character_selector = sel_q;
   assign segment            = seg_q;
   assign busy               = state_q != IDLE;
   assign overflow           = ovf_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench; expected digit frames are queued at load
// time and popped as the scan presents each digit.
module tb_seg_scan_ctrl;
   logic        clk = 1'b0;
   logic        reset_n, load, mode, blank_lz;
   logic [15:0] data_in;
   logic [3:0]  dp_in, brightness, character_selector;
   logic [7:0]  segment;
   logic        busy, overflow;
   logic [11:0] exp_q[$];
   int          n_cmp = 0, n_err = 0;

   seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(8), .SCAN_HZ(1), .DATA_W(16), .BRIGHT_W(4),
                   .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .data_in(data_in), .mode(mode),
      .dp_in(dp_in), .blank_lz(blank_lz), .brightness(brightness),
      .character_selector(character_selector), .segment(segment), .busy(busy),
      .overflow(overflow));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
      endcase
   endfunction

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input bit dash, input bit blz);
      logic [11:0] e[4];
      logic [6:0]  g;
      logic [3:0]  n, s;
      bit          lead;
      lead = 1;
      for (int d = 3; d >= 0; d--) begin
         n    = v[4*d +: 4];
         lead = lead && n == 4'd0 && d != 0 && blz && !dash;
         g    = dash ? 7'h40 : lead ? 7'h00 : glyph(n);
         s    = 4'hF;
         s[d] = 1'b0;
         e[d] = {s, ~{dp[d], g}};
      end
      for (int d = 0; d < 4; d++) exp_q.push_back(e[d]);
   endtask

   task automatic wait_sel(input logic [3:0] s);
      int w;
      w = 0;
      while (character_selector !== s && w < 200) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic check_frame(input string tag);
      logic [11:0] e;
      for (int d = 0; d < 4; d++) begin
         e = exp_q.pop_front();
         wait_sel(e[11:8]);
         chk($sformatf("%s sel d%0d", tag, d), character_selector, e[11:8]);
         chk($sformatf("%s seg d%0d", tag, d), segment, e[7:0]);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic m, input logic [3:0] dp);
      @(negedge clk);
      data_in = v;
      mode    = m;
      dp_in   = dp;
      load    = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("busy_done", busy, 0);
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      reset_n = 1'b0; load = 1'b1; mode = 1'b0; data_in = 16'hFFFF; dp_in = 4'h0;
      blank_lz = 1'b0; brightness = 4'hF;
      repeat (3) @(negedge clk);
      chk("rst sel", character_selector, 4'hF);
      chk("rst seg", segment, 8'hFF);
      chk("rst busy", busy, 0);
      chk("rst ovf", overflow, 0);
      load = 1'b0;
      reset_n = 1'b1;
      push_frame(16'h0000, 4'h0, 0, 0);
      check_frame("post_rst");

      do_load(16'hA5C3, 1'b0, 4'b0100);
      push_frame(16'hA5C3, 4'b0100, 0, 0);
      check_frame("hex");
      wait_sel(4'b0111);
      wait_sel(4'b1110);
      cnt = 0;
      while (character_selector === 4'b1110 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("scan_div", cnt, 8);
      chk("hex next sel", character_selector, 4'b1101);

      @(negedge clk);
      data_in = 16'd1234; mode = 1'b1; dp_in = 4'h0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         data_in = 16'd9;
         load = cnt == 5;
         @(negedge clk);
         cnt++;
      end
      load = 1'b0;
      chk("busy_len", cnt, 17);
      @(negedge clk);
      chk("dec ovf", overflow, 0);
      push_frame(16'h1234, 4'h0, 0, 0);
      check_frame("dec1234");

      do_load(16'd10000, 1'b1, 4'b0001);
      wait_idle();
      chk("ovf set", overflow, 1);
      push_frame(16'h0000, 4'b0001, 1, 0);
      check_frame("ovf");

      blank_lz = 1'b1;
      do_load(16'd7, 1'b1, 4'h0);
      wait_idle();
      chk("ovf clr", overflow, 0);
      push_frame(16'h0007, 4'h0, 0, 1);
      check_frame("blank7");

      do_load(16'h0000, 1'b0, 4'h0);
      push_frame(16'h0000, 4'h0, 0, 1);
      check_frame("blank0");

      brightness = 4'd4;
      repeat (3) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (character_selector !== 4'hF) cnt++;
         @(negedge clk);
      end
      chk("pwm4 on", cnt, 4);
      brightness = 4'd0;
      repeat (3) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         if (character_selector !== 4'hF || segment !== 8'hFF) cnt++;
         @(negedge clk);
      end
      chk("pwm0 on", cnt, 0);

      brightness = 4'hF;
      blank_lz = 1'b0;
      do_load(16'd4321, 1'b1, 4'b1111);
      repeat (4) @(negedge clk);
      chk("mid busy", busy, 1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("abort busy", busy, 0);
      chk("abort ovf", overflow, 0);
      repeat (30) @(negedge clk);
      chk("abort idle", busy, 0);
      push_frame(16'h0000, 4'h0, 0, 0);
      check_frame("abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
